// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter_pkg
//  Purpose  : Shared types for the data-memory arbiter and its load tracker:
//             request bundle, load owner identity and tracker entry states.
//  Revision : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  // Which requester issued a load; the value doubles as the port index.
  typedef enum logic {
    OWNER_RETIRE = 1'b0,
    OWNER_DBG    = 1'b1
  } dmem_owner_t;

  // Lifecycle of one load-tracker entry.
  typedef enum logic [1:0] {
    FREE    = 2'd0,
    PENDING = 2'd1,
    DROPPED = 2'd2
  } ld_entry_state_t;

  // One memory request as presented by a requester.
  typedef struct packed {
    logic        rd_en;
    logic [3:0]  wr_en;
    logic [31:0] addr;
    logic [31:0] data;
  } dmem_req_t;

  localparam dmem_req_t C_REQ_IDLE = '0;

  // A request with neither load nor store strobes is a no-op.
  function automatic logic req_is_access(input dmem_req_t r);
    return r.rd_en || (|r.wr_en);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ld_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_ld_tracker
//  Purpose  : Tracks outstanding loads and routes memory responses back to
//             the requester that issued them, oldest matching entry first.
//  Ports    : clk, rst            - clock, asynchronous active-high reset
//             flush               - drops every pending port-0 load
//             alloc/alloc_owner/alloc_idx - new load to record
//             rsp_valid/rsp_idx/rsp_data  - memory response
//             has_free            - a load could be accepted this cycle
//             resp_valid/resp_data - registered response to the requesters
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_ld_tracker
  import dmem_arbiter_pkg::*;
#(
  parameter int  MAX_OUTSTANDING = 4,
  parameter int  AW              = 10,
  parameter bit  STRICT_RESP     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc,
  input  dmem_owner_t       alloc_owner,
  input  logic [AW-1:0]     alloc_idx,
  input  logic              rsp_valid,
  input  logic [AW-1:0]     rsp_idx,
  input  logic [31:0]       rsp_data,
  output logic              has_free,
  output logic [1:0]        resp_valid,
  output logic [31:0]       resp_data
);

  localparam int AGE_W = $clog2(2 * MAX_OUTSTANDING);
  localparam int IDX_W = $clog2(MAX_OUTSTANDING);

  ld_entry_state_t   r_state     [MAX_OUTSTANDING];
  ld_entry_state_t   w_state_nxt [MAX_OUTSTANDING];
  dmem_owner_t       r_owner     [MAX_OUTSTANDING];
  logic [AW-1:0]     r_idx       [MAX_OUTSTANDING];
  logic [AGE_W-1:0]  r_age       [MAX_OUTSTANDING];
  logic [AGE_W-1:0]  r_age_ctr;

  logic              w_hit;
  logic [IDX_W-1:0]  w_hit_sel;
  logic              w_deliver;
  logic              w_alloc_ok;
  logic [IDX_W-1:0]  w_alloc_sel;
  logic [1:0]        r_resp_valid;
  logic [31:0]       r_resp_data;

  // Ages wrap modulo 2*MAX_OUTSTANDING; at most MAX_OUTSTANDING are live, so
  // the sign of the modular difference tells which one was allocated first.
  function automatic logic is_older(input logic [AGE_W-1:0] a,
                                    input logic [AGE_W-1:0] b);
    logic [AGE_W-1:0] d;
    d = a - b;
    return d[AGE_W-1];
  endfunction

  // Response match: oldest live entry carrying the returned word index.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_sel = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rsp_valid && (r_state[i] != FREE) && (r_idx[i] == rsp_idx)) begin
        if (!w_hit || is_older(r_age[i], r_age[w_hit_sel])) begin
          w_hit     = 1'b1;
          w_hit_sel = IDX_W'(i);
        end
      end
    end
  end

  // A flush in the same cycle discards a response aimed at port 0.
  assign w_deliver = w_hit && (r_state[w_hit_sel] == PENDING) &&
                     !(flush && (r_owner[w_hit_sel] == OWNER_RETIRE));

  // Lowest free entry, counting the one this cycle's response releases, so a
  // full tracker can accept a load in the same cycle a response returns.
  always_comb begin
    w_alloc_ok  = 1'b0;
    w_alloc_sel = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if ((r_state[i] == FREE) || (w_hit && (w_hit_sel == IDX_W'(i)))) begin
        w_alloc_ok  = 1'b1;
        w_alloc_sel = IDX_W'(i);
      end
    end
  end

  assign has_free = w_alloc_ok;

  // Entry next-state: release, then drop on flush, then allocate.
  always_comb begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      w_state_nxt[i] = r_state[i];
      if (w_hit && (w_hit_sel == IDX_W'(i))) begin
        w_state_nxt[i] = FREE;
      end else if (flush && (r_state[i] == PENDING) &&
                   (r_owner[i] == OWNER_RETIRE)) begin
        w_state_nxt[i] = DROPPED;
      end
      if (alloc && w_alloc_ok && (w_alloc_sel == IDX_W'(i))) begin
        w_state_nxt[i] = PENDING;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_state[i] <= FREE;
        r_owner[i] <= OWNER_RETIRE;
        r_idx[i]   <= '0;
        r_age[i]   <= '0;
      end
      r_age_ctr    <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
    end else begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        r_state[i] <= w_state_nxt[i];
      end
      if (alloc && w_alloc_ok) begin
        r_owner[w_alloc_sel] <= alloc_owner;
        r_idx[w_alloc_sel]   <= alloc_idx;
        r_age[w_alloc_sel]   <= r_age_ctr;
        r_age_ctr            <= r_age_ctr + 1'b1;
      end
      r_resp_valid <= '0;
      if (w_deliver) begin
        r_resp_valid <= (r_owner[w_hit_sel] == OWNER_DBG) ? 2'b10 : 2'b01;
        r_resp_data  <= rsp_data;
      end
    end
  end

  // A response that matches nothing is ignored; flag it in simulation.
  always_ff @(posedge clk) begin
    if (STRICT_RESP && !rst) begin
      assert (!(rsp_valid && !w_hit))
        else $error("dmem_ld_tracker: response idx 0x%0h matches no entry", rsp_idx);
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_arbiter
//  Purpose  : Round-robin sharing of the data-memory port between the retire
//             path (port 0) and the debug/DMA path (port 1), with load
//             tracking and flush cancellation of port-0 loads.
//  Ports    : clk, rst              - clock, asynchronous active-high reset
//             flush                 - mispredict; cancels port-0 traffic
//             req_*                 - per-port request, req_ready = grant
//             resp_valid/resp_data  - registered load return
//             dmem_*                - registered strobe to memory / response
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int MEM_DEPTH       = 1024,
  parameter int AW              = $clog2(MEM_DEPTH),
  parameter bit STRICT_RESP     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][3:0]  req_wr_en,
  input  logic [1:0]       req_rd_en,
  input  logic [1:0][31:0] req_addr,
  input  logic [1:0][31:0] req_data,
  output logic [1:0]       resp_valid,
  output logic [31:0]      resp_data,
  output logic [3:0]       dmem_wr_en,
  output logic             dmem_rd_en,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_data_out,
  input  logic             dmem_valid_in,
  input  logic [AW-1:0]    dmem_valid_addr_in,
  input  logic [31:0]      dmem_data_in
);

  logic       r_prio;      // port favoured when both are eligible
  dmem_req_t  r_issue;
  logic [1:0] w_elig;
  logic [1:0] w_grant;
  logic       w_gport;
  dmem_req_t  w_sel;
  dmem_req_t  w_issue;
  logic       w_alloc;
  logic       w_has_free;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_elig[p] = req_valid[p] && (!req_rd_en[p] || w_has_free);
    end
    if (flush) begin
      w_elig[0] = 1'b0;
    end

    w_grant = w_elig;
    if (&w_elig) begin
      w_grant = r_prio ? 2'b10 : 2'b01;
    end
    w_gport = w_grant[1];

    w_sel.rd_en = req_rd_en[w_gport];
    w_sel.wr_en = req_wr_en[w_gport];
    w_sel.addr  = req_addr[w_gport];
    w_sel.data  = req_data[w_gport];

    // No-op grants are accepted but put nothing on the memory port; loads
    // carry no write data.
    w_issue = C_REQ_IDLE;
    if ((|w_grant) && req_is_access(w_sel)) begin
      w_issue = w_sel;
      if (~|w_sel.wr_en) begin
        w_issue.data = '0;
      end
    end

    w_alloc = (|w_grant) && w_sel.rd_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio  <= 1'b0;
      r_issue <= C_REQ_IDLE;
    end else begin
      if (|w_grant) begin
        r_prio <= ~w_gport;
      end
      r_issue <= w_issue;
    end
  end

  dmem_ld_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .AW              (AW),
    .STRICT_RESP     (STRICT_RESP)
  ) u_trk (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .alloc       (w_alloc),
    .alloc_owner (dmem_owner_t'(w_gport)),
    .alloc_idx   (w_sel.addr[AW+1:2]),
    .rsp_valid   (dmem_valid_in),
    .rsp_idx     (dmem_valid_addr_in),
    .rsp_data    (dmem_data_in),
    .has_free    (w_has_free),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data)
  );

  assign req_ready     = w_grant;
  assign dmem_rd_en    = r_issue.rd_en;
  assign dmem_wr_en    = r_issue.wr_en;
  assign dmem_addr     = r_issue.addr;
  assign dmem_data_out = r_issue.data;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_arbiter
//  Purpose  : Directed self-checking bench for dmem_arbiter. Expected memory
//             issues and responses are queued as stimulus is applied and
//             compared when the design produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][3:0]  req_wr_en;
  logic [1:0]       req_rd_en;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_data;
  logic [1:0]       resp_valid;
  logic [31:0]      resp_data;
  logic [3:0]       dmem_wr_en;
  logic             dmem_rd_en;
  logic [31:0]      dmem_addr;
  logic [31:0]      dmem_data_out;
  logic             dmem_valid_in;
  logic [AW-1:0]    dmem_valid_addr_in;
  logic [31:0]      dmem_data_in;

  // Orphan responses are sent on purpose after a mid-flight reset.
  dmem_arbiter #(
    .MAX_OUTSTANDING (4),
    .MEM_DEPTH       (1024),
    .AW              (AW),
    .STRICT_RESP     (1'b0)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_wr_en          (req_wr_en),
    .req_rd_en          (req_rd_en),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .resp_valid         (resp_valid),
    .resp_data          (resp_data),
    .dmem_wr_en         (dmem_wr_en),
    .dmem_rd_en         (dmem_rd_en),
    .dmem_addr          (dmem_addr),
    .dmem_data_out      (dmem_data_out),
    .dmem_valid_in      (dmem_valid_in),
    .dmem_valid_addr_in (dmem_valid_addr_in),
    .dmem_data_in       (dmem_data_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [3:0]  wr;
    logic [31:0] addr;
    logic [31:0] data;
  } issue_t;

  typedef struct packed {
    logic [1:0]  valid;
    logic [31:0] data;
  } resp_t;

  issue_t q_issue[$];
  resp_t  q_resp[$];
  int     checks   = 0;
  int     failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  task automatic idle_inputs();
    flush              = 1'b0;
    req_valid          = '0;
    req_rd_en          = '0;
    req_wr_en          = '0;
    req_addr           = '0;
    req_data           = '0;
    dmem_valid_in      = 1'b0;
    dmem_valid_addr_in = '0;
    dmem_data_in       = '0;
  endtask

  task automatic req(input int p, input logic rd, input logic [3:0] wr,
                     input logic [31:0] addr, input logic [31:0] data);
    req_valid[p] = 1'b1;
    req_rd_en[p] = rd;
    req_wr_en[p] = wr;
    req_addr[p]  = addr;
    req_data[p]  = data;
  endtask

  task automatic rsp(input logic [AW-1:0] idx, input logic [31:0] data);
    dmem_valid_in      = 1'b1;
    dmem_valid_addr_in = idx;
    dmem_data_in       = data;
  endtask

  // Called at a falling edge with the cycle's inputs applied: checks the
  // grant, queues the expected issue and response, then after the rising
  // edge pops and compares both and returns inputs to idle.
  task automatic step(input string tag, input logic [1:0] exp_ready,
                      input logic [1:0] exp_resp, input logic [31:0] exp_rdata);
    issue_t e;
    resp_t  r;
    int     p;
    #1;
    chk({tag, ".ready"}, 64'(req_ready), 64'(exp_ready));
    e = '0;
    if (exp_ready != 2'b00) begin
      p    = exp_ready[1] ? 1 : 0;
      e.rd = req_rd_en[p];
      e.wr = req_wr_en[p];
      if (e.rd || (|e.wr)) e.addr = req_addr[p];
      if (|e.wr)           e.data = req_data[p];
    end
    q_issue.push_back(e);
    r.valid = exp_resp;
    r.data  = exp_rdata;
    q_resp.push_back(r);

    @(posedge clk);
    #1;
    e = q_issue.pop_front();
    chk({tag, ".rd_en"},   64'(dmem_rd_en),    64'(e.rd));
    chk({tag, ".wr_en"},   64'(dmem_wr_en),    64'(e.wr));
    chk({tag, ".addr"},    64'(dmem_addr),     64'(e.addr));
    chk({tag, ".wdata"},   64'(dmem_data_out), 64'(e.data));
    r = q_resp.pop_front();
    chk({tag, ".rvalid"},  64'(resp_valid),    64'(r.valid));
    if (r.valid != 2'b00) begin
      chk({tag, ".rdata"}, 64'(resp_data),     64'(r.data));
    end
    @(negedge clk);
    idle_inputs();
  endtask

  // Loads with write strobes are illegal stimulus.
  always @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      assert (!(req_valid[p] && req_rd_en[p] && (|req_wr_en[p])))
        else begin
          failures++;
          $error("FAIL illegal_req port=%0d observed=rd+wr required=one", p);
        end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset.rd_en",  64'(dmem_rd_en),    64'd0);
    chk("reset.wr_en",  64'(dmem_wr_en),    64'd0);
    chk("reset.addr",   64'(dmem_addr),     64'd0);
    chk("reset.wdata",  64'(dmem_data_out), 64'd0);
    chk("reset.rvalid", 64'(resp_valid),    64'd0);
    chk("reset.rdata",  64'(resp_data),     64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Continuous stores on both ports alternate starting with port 0.
    for (int k = 0; k < 4; k++) begin
      req(0, 1'b0, 4'hF, 32'h200, 32'hA5A5A5A5);
      req(1, 1'b0, 4'hF, 32'h300, 32'h5A5A5A5A);
      step("st.alt", (k % 2 == 0) ? 2'b01 : 2'b10, 2'b00, 32'h0);
    end
    step("st.idle", 2'b00, 2'b00, 32'h0);

    // Single port-0 load and its response.
    req(0, 1'b1, 4'h0, 32'h40, 32'h0);
    step("ld0.issue", 2'b01, 2'b00, 32'h0);
    rsp(10'h010, 32'hDEADBEEF);
    step("ld0.resp", 2'b00, 2'b01, 32'hDEADBEEF);
    step("ld0.idle", 2'b00, 2'b00, 32'h0);

    // Fill the tracker from port 1; the fifth load waits for a response.
    for (int k = 0; k < 4; k++) begin
      req(1, 1'b1, 4'h0, 32'h500 + 32'(4 * k), 32'h0);
      step("full.fill", 2'b10, 2'b00, 32'h0);
    end
    req(1, 1'b1, 4'h0, 32'h510, 32'h0);
    step("full.block", 2'b00, 2'b00, 32'h0);
    req(1, 1'b1, 4'h0, 32'h510, 32'h0);
    step("full.block2", 2'b00, 2'b00, 32'h0);
    req(1, 1'b1, 4'h0, 32'h510, 32'h0);
    rsp(10'h140, 32'h11111111);
    step("full.reuse", 2'b10, 2'b10, 32'h11111111);
    for (int k = 1; k < 5; k++) begin
      rsp(10'h140 + 10'(k), 32'h1000_0000 + 32'(k));
      step("full.drain", 2'b00, 2'b10, 32'h1000_0000 + 32'(k));
    end

    // Flush drops port-0 loads, leaves port-1 traffic intact.
    req(0, 1'b1, 4'h0, 32'h100, 32'h0);
    step("fl.ld0a", 2'b01, 2'b00, 32'h0);
    req(0, 1'b1, 4'h0, 32'h104, 32'h0);
    step("fl.ld0b", 2'b01, 2'b00, 32'h0);
    req(1, 1'b1, 4'h0, 32'h600, 32'h0);
    step("fl.ld1", 2'b10, 2'b00, 32'h0);
    flush = 1'b1;
    req(0, 1'b1, 4'h0, 32'h108, 32'h0);
    req(1, 1'b0, 4'hF, 32'h320, 32'h77777777);
    step("fl.flush", 2'b10, 2'b00, 32'h0);
    rsp(10'h040, 32'hBAD00000);
    step("fl.drop_a", 2'b00, 2'b00, 32'h0);
    rsp(10'h041, 32'hBAD00001);
    step("fl.drop_b", 2'b00, 2'b00, 32'h0);
    rsp(10'h180, 32'h22222222);
    step("fl.p1resp", 2'b00, 2'b10, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      chk("fl.entry_free", 64'(dut.u_trk.r_state[i]), 64'(FREE));
    end

    // Same address from both ports: responses follow allocation age, even
    // when the younger load occupies the lower-numbered entry.
    req(1, 1'b1, 4'h0, 32'h7F0, 32'h0);
    step("age.pad", 2'b10, 2'b00, 32'h0);
    req(0, 1'b1, 4'h0, 32'h700, 32'h0);
    step("age.ld0", 2'b01, 2'b00, 32'h0);
    rsp(10'h1FC, 32'h55555555);
    step("age.padresp", 2'b00, 2'b10, 32'h55555555);
    req(1, 1'b1, 4'h0, 32'h700, 32'h0);
    step("age.ld1", 2'b10, 2'b00, 32'h0);
    rsp(10'h1C0, 32'h33333333);
    step("age.first", 2'b00, 2'b01, 32'h33333333);
    rsp(10'h1C0, 32'h44444444);
    step("age.second", 2'b00, 2'b10, 32'h44444444);

    // Reset with three loads outstanding.
    for (int k = 0; k < 3; k++) begin
      req(1, 1'b1, 4'h0, 32'h800 + 32'(4 * k), 32'h0);
      step("rst.fill", 2'b10, 2'b00, 32'h0);
    end
    chk("rst.pre_rd", 64'(dmem_rd_en), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst.rd_en",  64'(dmem_rd_en), 64'd0);
    chk("rst.addr",   64'(dmem_addr),  64'd0);
    chk("rst.rvalid", 64'(resp_valid), 64'd0);
    chk("rst.rdata",  64'(resp_data),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    rsp(10'h200, 32'hBAD00002);
    step("rst.orphan", 2'b00, 2'b00, 32'h0);
    req(1, 1'b1, 4'h0, 32'h900, 32'h0);
    step("rst.newld", 2'b10, 2'b00, 32'h0);
    chk("rst.entry0", 64'(dut.u_trk.r_state[0]), 64'(PENDING));
    chk("rst.entry1", 64'(dut.u_trk.r_state[1]), 64'(FREE));
    rsp(10'h240, 32'h66666666);
    step("rst.newresp", 2'b00, 2'b10, 32'h66666666);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
